// File: rtl/count_pkg.sv
// Shared definitions for the count sequence checker: state encoding and default count width.
package count_pkg;

   localparam int COUNT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_TRACK = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once full.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that valid count samples advance by one (mod 2^WIDTH); reports lock, errors, wraps, fault.
// Optional COUNT_SEQ_CHECKER_CAPTURE_EN adds first_exp/first_act capture of the first tracked mismatch.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | no history; next valid sample seeds prev
//   ST_SYNC  | have one sample; waiting for a correct successor
//   ST_TRACK | locked; mismatches are counted toward fault
//   ST_FAULT | ERR_LIMIT consecutive mismatches seen; frozen until clr/rst
module count_seq_checker
   import count_pkg::*;
#(
   parameter int WIDTH     = COUNT_WIDTH,
   parameter int ERR_LIMIT = 3,
   parameter int WRAP_W    = 8,
   parameter int ERR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              count_vld,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              fault
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
   ,
   output logic [WIDTH-1:0]  first_exp,
   output logic [WIDTH-1:0]  first_act
`endif
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] prev, prev_nxt;
   logic [3:0]       consec, consec_nxt;
   logic             locked_nxt, err_pulse_nxt, fault_nxt;
   logic             err_inc, wrap_inc;
   logic [WIDTH-1:0] exp_val;
   logic [3:0]       consec_inc;
   logic             match;

   assign exp_val    = prev + 1'b1;
   assign match      = (count_in == exp_val);
   assign consec_inc = consec + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         prev      <= '0;
         consec    <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         prev      <= prev_nxt;
         consec    <= consec_nxt;
         locked    <= locked_nxt;
         err_pulse <= err_pulse_nxt;
         fault     <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      prev_nxt      = prev;
      consec_nxt    = consec;
      locked_nxt    = locked;
      err_pulse_nxt = 1'b0;
      fault_nxt     = fault;
      err_inc       = 1'b0;
      wrap_inc      = 1'b0;
      if (clr) begin
         state_nxt  = ST_IDLE;
         prev_nxt   = '0;
         consec_nxt = '0;
         locked_nxt = 1'b0;
         fault_nxt  = 1'b0;
      end else if (count_vld) begin
         unique case (state)
            ST_IDLE: begin
               prev_nxt  = count_in;
               state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
               prev_nxt = count_in;
               if (match) begin
                  state_nxt  = ST_TRACK;
                  locked_nxt = 1'b1;
               end
            end
            ST_TRACK: begin
               prev_nxt = count_in;
               if (match) begin
                  consec_nxt = '0;
                  wrap_inc   = (prev == '1);
               end else begin
                  err_pulse_nxt = 1'b1;
                  err_inc       = 1'b1;
                  consec_nxt    = consec_inc;
                  if (consec_inc == 4'(ERR_LIMIT)) begin
                     state_nxt  = ST_FAULT;
                     locked_nxt = 1'b0;
                     fault_nxt  = 1'b1;
                  end
               end
            end
            ST_FAULT: begin
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (err_inc),
      .cnt (err_cnt)
   );

   sat_counter #(.W(WRAP_W)) u_wrap_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (wrap_inc),
      .cnt (wrap_cnt)
   );

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
   logic captured;

   // Only the first mismatch since reset/clr is kept; later ones leave the capture untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         captured  <= 1'b0;
         first_exp <= '0;
         first_act <= '0;
      end else if (clr) begin
         captured  <= 1'b0;
         first_exp <= '0;
         first_act <= '0;
      end else if (err_inc && !captured) begin
         captured  <= 1'b1;
         first_exp <= exp_val;
         first_act <= count_in;
      end
   end
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed scenarios plus random count streams.
module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic       count_vld = 1'b0;
   logic       locked, err_pulse, fault;
   logic [7:0] err_cnt, wrap_cnt;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
   logic [3:0] first_exp, first_act;
`endif

   int errors = 0;
   int checks = 0;

   count_seq_checker dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .count_in  (count_in),
      .count_vld (count_vld),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .wrap_cnt  (wrap_cnt),
      .fault     (fault)
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
      ,
      .first_exp (first_exp),
      .first_act (first_act)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit locked;
      bit err_pulse;
      int err_cnt;
      int wrap_cnt;
      bit fault;
   } exp_t;

   exp_t q[$];

   // Reference model: plain history flags and integer counters.
   bit m_have, m_locked, m_fault, m_pulse;
   int m_prev, m_consec, m_err, m_wrap;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_clear();
      m_have = 0; m_locked = 0; m_fault = 0; m_pulse = 0;
      m_prev = 0; m_consec = 0; m_err = 0; m_wrap = 0;
   endfunction

   task automatic step(input bit vld, input int val, input bit c);
      exp_t e;
      @(negedge clk);
      count_vld = vld;
      count_in  = 4'(val);
      clr       = c;
      m_pulse   = 0;
      if (c) begin
         model_clear();
      end else if (vld && !m_fault) begin
         if (!m_have) begin
            m_have = 1;
         end else if (val == (m_prev + 1) % 16) begin
            if (m_locked) begin
               if (m_prev == 15 && m_wrap < 255) m_wrap++;
               m_consec = 0;
            end
            m_locked = 1;
         end else if (m_locked) begin
            m_pulse = 1;
            if (m_err < 255) m_err++;
            m_consec++;
            if (m_consec == 3) begin
               m_fault  = 1;
               m_locked = 0;
            end
         end
         m_prev = val;
      end
      e.locked = m_locked; e.err_pulse = m_pulse; e.err_cnt = m_err;
      e.wrap_cnt = m_wrap; e.fault = m_fault;
      q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("locked",    int'(locked),    int'(e.locked));
            chk("err_pulse", int'(err_pulse), int'(e.err_pulse));
            chk("err_cnt",   int'(err_cnt),   e.err_cnt);
            chk("wrap_cnt",  int'(wrap_cnt),  e.wrap_cnt);
            chk("fault",     int'(fault),     int'(e.fault));
         end
      end
   end

   initial begin : stim
      int gen;
      model_clear();
      #12;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_fault", int'(fault), 0);
      @(negedge clk);
      rst = 1'b1;

      // Lock on 0,1,2.
      step(1, 0, 0); step(1, 1, 0); settle();
      chk("lock_after_2nd", int'(locked), 1);
      step(1, 2, 0); settle();
      chk("lock_err_cnt", int'(err_cnt), 0);
      chk("lock_wrap_cnt", int'(wrap_cnt), 0);

      // Two full wraps.
      for (int i = 3; i < 16; i++) step(1, i, 0);
      for (int i = 0; i < 16; i++) step(1, i, 0);
      step(1, 0, 0); settle();
      chk("wrap_two", int'(wrap_cnt), 2);
      chk("wrap_no_err", int'(err_cnt), 0);

      // Isolated mismatch: locked at 5, then 9, 10, 11.
      for (int i = 1; i <= 5; i++) step(1, i, 0);
      step(1, 9, 0); settle();
      chk("single_pulse", int'(err_pulse), 1);
      chk("single_err_cnt", int'(err_cnt), 1);
      chk("single_locked", int'(locked), 1);
      step(1, 10, 0); settle();
      chk("pulse_cleared", int'(err_pulse), 0);
      step(1, 11, 0);

      // Three consecutive mismatches -> fault; 12 ignored.
      step(1, 3, 0); step(1, 7, 0); step(1, 1, 0); settle();
      chk("fault_set", int'(fault), 1);
      chk("fault_unlocked", int'(locked), 0);
      chk("fault_err_cnt", int'(err_cnt), 4);
      step(1, 12, 0); step(1, 13, 0); settle();
      chk("fault_frozen", int'(err_cnt), 4);

      // clr with simultaneous vld: sample dropped.
      step(1, 5, 1); settle();
      chk("clr_fault", int'(fault), 0);
      chk("clr_err_cnt", int'(err_cnt), 0);
      chk("clr_wrap_cnt", int'(wrap_cnt), 0);
      step(1, 6, 0); settle();
      chk("clr_dropped", int'(locked), 0);
      step(1, 7, 0); step(1, 8, 0); settle();
      chk("relock", int'(locked), 1);

      // Async reset mid-TRACK, between edges.
      @(negedge clk);
      #1;
      count_vld = 1'b0;
      rst = 1'b0;
      #1;
      chk("async_locked", int'(locked), 0);
      chk("async_err_cnt", int'(err_cnt), 0);
      chk("async_wrap_cnt", int'(wrap_cnt), 0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      step(1, 4, 0); step(1, 5, 0); settle();
      chk("post_rst_lock", int'(locked), 1);

      // Random stream: mostly in sequence, with gaps, jumps, stalls, rare clears.
      gen = 5;
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(99, 0));
         if (r < 1) begin
            step(1, int'($urandom_range(15, 0)), 1);
         end else if (r < 20) begin
            step(0, int'($urandom_range(15, 0)), 0);
         end else if (r < 26) begin
            gen = int'($urandom_range(15, 0));
            step(1, gen, 0);
         end else if (r < 29) begin
            step(1, gen, 0);
         end else begin
            gen = (gen + 1) % 16;
            step(1, gen, 0);
         end
      end

      step(0, 0, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #3;
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
